// File: rtl/alu_issue_if.sv
// Fetch / regfile / ALU / writeback / branch signals seen by the ALU issue controller.
// The master modport is the controller side; the slave modport is its environment.
interface alu_issue_if #(
  parameter int MAX_SIZE   = 32,
  parameter int REG_ADDR_W = 5
);
  logic                  instr_valid;
  logic                  instr_ready;
  logic [31:0]           instr;
  logic [REG_ADDR_W-1:0] rs1_addr;
  logic [REG_ADDR_W-1:0] rs2_addr;
  logic [MAX_SIZE-1:0]   rs1_data;
  logic [MAX_SIZE-1:0]   rs2_data;
  logic [MAX_SIZE-1:0]   alu_in0;
  logic [MAX_SIZE-1:0]   alu_in1;
  logic [2:0]            alu_op;
  logic [MAX_SIZE-1:0]   alu_result;
  logic                  alu_zero;
  logic                  wb_valid;
  logic                  wb_ready;
  logic [REG_ADDR_W-1:0] wb_addr;
  logic [MAX_SIZE-1:0]   wb_data;
  logic                  br_valid;
  logic                  br_taken;
  logic                  illegal;

  modport master (
    input  instr_valid, instr, rs1_data, rs2_data, alu_result, alu_zero, wb_ready,
    output instr_ready, rs1_addr, rs2_addr, alu_in0, alu_in1, alu_op,
           wb_valid, wb_addr, wb_data, br_valid, br_taken, illegal
  );

  modport slave (
    output instr_valid, instr, rs1_data, rs2_data, alu_result, alu_zero, wb_ready,
    input  instr_ready, rs1_addr, rs2_addr, alu_in0, alu_in1, alu_op,
           wb_valid, wb_addr, wb_data, br_valid, br_taken, illegal
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: one instruction in flight, accept->wb_valid 3 cycles, held until wb_ready.
// Optional ALU_ISSUE_STATS_EN adds retired_cnt/illegal_cnt outputs.
module alu_issue_ctrl #(
  parameter int MAX_SIZE   = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_issue_if.master  bus
`ifdef ALU_ISSUE_STATS_EN
  ,
  output logic [31:0]  retired_cnt,
  output logic [15:0]  illegal_cnt
`endif
);

  localparam logic [6:0] OPC_R = 7'b0110011;
  localparam logic [6:0] OPC_I = 7'b0010011;
  localparam logic [6:0] OPC_B = 7'b1100011;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;

  typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_t;

  state_t                state_q;
  logic [31:0]           instr_q;
  logic                  is_br_q;
  logic                  is_bne_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic [MAX_SIZE-1:0]   alu_in0_q;
  logic [MAX_SIZE-1:0]   alu_in1_q;
  logic [2:0]            alu_op_q;
  logic                  wb_valid_q;
  logic [REG_ADDR_W-1:0] wb_addr_q;
  logic [MAX_SIZE-1:0]   wb_data_q;
  logic                  br_valid_q;
  logic                  br_taken_q;
  logic                  illegal_q;

  logic                  legal_d;
  logic [2:0]            alu_op_d;
  logic [MAX_SIZE-1:0]   alu_in1_d;
  logic                  is_br_d;
  logic                  is_bne_d;
  logic [MAX_SIZE-1:0]   imm_sext;
  logic [6:0]            opcode;
  logic [2:0]            funct3;

  assign opcode   = instr_q[6:0];
  assign funct3   = instr_q[14:12];
  assign imm_sext = {{(MAX_SIZE-12){instr_q[31]}}, instr_q[31:20]};

  // Decode of the latched word; only consumed while in DECODE.
  always_comb begin
    legal_d   = 1'b0;
    alu_op_d  = OP_ADD;
    alu_in1_d = bus.rs2_data;
    is_br_d   = 1'b0;
    is_bne_d  = 1'b0;
    case (opcode)
      OPC_R, OPC_I: begin
        legal_d = 1'b1;
        case (funct3)
          3'b000:  alu_op_d = (opcode == OPC_R && instr_q[30]) ? OP_SUB : OP_ADD;
          3'b111:  alu_op_d = OP_AND;
          3'b110:  alu_op_d = OP_OR;
          3'b100:  alu_op_d = OP_XOR;
          3'b010:  alu_op_d = OP_SLT;
          default: legal_d  = 1'b0;
        endcase
        if (opcode == OPC_I) alu_in1_d = imm_sext;
      end
      OPC_B: begin
        legal_d  = (funct3 == 3'b000) || (funct3 == 3'b001);
        alu_op_d = OP_SUB;
        is_br_d  = 1'b1;
        is_bne_d = funct3[0];
      end
      default: legal_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      instr_q    <= '0;
      is_br_q    <= 1'b0;
      is_bne_q   <= 1'b0;
      rd_q       <= '0;
      alu_in0_q  <= '0;
      alu_in1_q  <= '0;
      alu_op_q   <= '0;
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      br_valid_q <= 1'b0;
      br_taken_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      br_valid_q <= 1'b0;
      illegal_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.instr_valid) begin
            instr_q <= bus.instr;
            state_q <= DECODE;
          end
        end
        DECODE: begin
          if (legal_d) begin
            alu_in0_q <= bus.rs1_data;
            alu_in1_q <= alu_in1_d;
            alu_op_q  <= alu_op_d;
            is_br_q   <= is_br_d;
            is_bne_q  <= is_bne_d;
            rd_q      <= instr_q[11:7];
            state_q   <= EXEC;
          end else begin
            illegal_q <= 1'b1;
            state_q   <= IDLE;
          end
        end
        EXEC: begin
          if (is_br_q) begin
            br_valid_q <= 1'b1;
            br_taken_q <= bus.alu_zero ^ is_bne_q;
            state_q    <= IDLE;
          end else if (rd_q == '0) begin
            state_q <= IDLE;
          end else begin
            wb_data_q  <= bus.alu_result;
            wb_addr_q  <= rd_q;
            wb_valid_q <= 1'b1;
            state_q    <= WB;
          end
        end
        WB: begin
          if (bus.wb_ready) begin
            wb_valid_q <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef ALU_ISSUE_STATS_EN
  logic [31:0] retired_q;
  logic [15:0] illegal_cnt_q;

  // Retirement = wb handshake, rd==0 discard, or resolved branch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      retired_q     <= '0;
      illegal_cnt_q <= '0;
    end else begin
      if ((state_q == WB && bus.wb_ready) || state_q == EXEC && (is_br_q || rd_q == '0))
        retired_q <= retired_q + 32'd1;
      if (state_q == DECODE && !legal_d)
        illegal_cnt_q <= illegal_cnt_q + 16'd1;
    end
  end

  assign retired_cnt = retired_q;
  assign illegal_cnt = illegal_cnt_q;
`endif

  // Gated by rst_n so nothing is accepted while reset is asserted.
  assign bus.instr_ready = rst_n && (state_q == IDLE);
  assign bus.rs1_addr    = instr_q[19:15];
  assign bus.rs2_addr    = instr_q[24:20];
  assign bus.alu_in0     = alu_in0_q;
  assign bus.alu_in1     = alu_in1_q;
  assign bus.alu_op      = alu_op_q;
  assign bus.wb_valid    = wb_valid_q;
  assign bus.wb_addr     = wb_addr_q;
  assign bus.wb_data     = wb_data_q;
  assign bus.br_valid    = br_valid_q;
  assign bus.br_taken    = br_taken_q;
  assign bus.illegal     = illegal_q;

endmodule
